// File: rtl/hazard_ctrl_unit.sv
// Hazard control for a five-stage MIPS pipeline: load-use / RAW stalls, branch flushes,
// optional EX forwarding selects (define HAZARD_FORWARDING_EN), saturating stall/flush counters.
module hazard_ctrl_unit #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_reg_write,
    input  logic [REG_AW-1:0] i_ex_dst,
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_dst,
    input  logic              i_mem_branch_taken,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_idex_bubble,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic              o_exmem_flush,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt,
    output logic              o_dbg_state
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t           r_state, w_next_state;
    logic [2:0]       r_fcnt, w_next_fcnt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_stall_inc, w_flush_inc;
    logic             w_load_use, w_hazard;

    // Destination x0 never matches, so dst!=0 is folded into the compare.
    function automatic logic id_hits(input logic [REG_AW-1:0] dst);
        return (dst != '0) && ((dst == i_id_rs) || (i_id_uses_rt && (dst == i_id_rt)));
    endfunction

    assign w_load_use = i_id_valid && i_ex_mem_read && id_hits(i_ex_dst);

`ifdef HAZARD_FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (i_mem_reg_write && (i_mem_dst != '0) && (i_mem_dst == src)) return 2'b10;
        if (i_wb_reg_write && (i_wb_dst != '0) && (i_wb_dst == src))    return 2'b01;
        return 2'b00;
    endfunction

    assign w_hazard = w_load_use;
    assign o_fwd_a  = reset ? 2'b00 : fwd_sel(i_ex_rs);
    assign o_fwd_b  = reset ? 2'b00 : fwd_sel(i_ex_rt);
`else
    logic w_unused_fwd_inputs;

    // Without forwarding any in-flight EX or MEM writer of an ID source must drain first.
    assign w_hazard = w_load_use
                    || (i_id_valid && i_ex_reg_write && id_hits(i_ex_dst))
                    || (i_id_valid && i_mem_reg_write && id_hits(i_mem_dst));
    assign o_fwd_a  = 2'b00;
    assign o_fwd_b  = 2'b00;
    assign w_unused_fwd_inputs = ^{i_ex_rs, i_ex_rt, i_wb_reg_write, i_wb_dst};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_fcnt  <= w_next_fcnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_fcnt   = r_fcnt;
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_idex_bubble = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_mem_branch_taken) begin
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = ST_FLUSH;
                        w_next_fcnt  = FCNT_RELOAD;
                    end
                end else if (w_hazard) begin
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                    w_stall_inc   = 1'b1;
                end
            end
            ST_FLUSH: begin
                o_ifid_flush = 1'b1;
                if (i_mem_branch_taken) begin
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                    w_next_fcnt   = FCNT_RELOAD;
                end else if (r_fcnt <= 3'd1) begin
                    w_next_state = ST_RUN;
                    w_next_fcnt  = '0;
                end else begin
                    w_next_fcnt = r_fcnt - 3'd1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_fcnt  = '0;
            end
        endcase

        // Reset freezes the front end and clears every pipeline register.
        if (reset) begin
            w_next_state  = ST_RUN;
            w_next_fcnt   = '0;
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            w_stall_inc   = 1'b0;
            w_flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_dbg_state = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus randomized traffic against a
// behavioural model built from the pipeline hazard/flush rules.
module tb_hazard_ctrl_unit;

    localparam int AW  = 5;
    localparam int FC  = 3;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rt, ex_mem_read, ex_reg_write;
    logic          mem_reg_write, wb_reg_write, mem_branch_taken;
    logic [AW-1:0] id_rs, id_rt, ex_dst, ex_rs, ex_rt, mem_dst, wb_dst;
    logic          pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl_unit #(.REG_AW(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
        .i_ex_mem_read(ex_mem_read), .i_ex_reg_write(ex_reg_write), .i_ex_dst(ex_dst),
        .i_ex_rs(ex_rs), .i_ex_rt(ex_rt),
        .i_mem_reg_write(mem_reg_write), .i_mem_dst(mem_dst),
        .i_wb_reg_write(wb_reg_write), .i_wb_dst(wb_dst),
        .i_mem_branch_taken(mem_branch_taken),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_idex_bubble(idex_bubble),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_exmem_flush(exmem_flush),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_rem   = 0;   // ifid-only flush cycles still owed after a taken branch
    int m_stall = 0;
    int m_flush = 0;
    int blockers[$];
    int srcs[$];
    logic e_pc, e_ifw, e_bub, e_f1, e_f2, e_f3, e_haz;
    logic [1:0] e_fa, e_fb;

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
        if (mem_reg_write && mem_dst != 0 && mem_dst == src) return 2'b10;
        if (wb_reg_write && wb_dst != 0 && wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        blockers = {};
        srcs = {};
        srcs.push_back(int'(id_rs));
        if (id_uses_rt) srcs.push_back(int'(id_rt));
        if (ex_mem_read) blockers.push_back(int'(ex_dst));
`ifndef HAZARD_FORWARDING_EN
        if (ex_reg_write) blockers.push_back(int'(ex_dst));
        if (mem_reg_write) blockers.push_back(int'(mem_dst));
`endif
        e_haz = 1'b0;
        if (id_valid)
            foreach (blockers[b])
                foreach (srcs[s])
                    if (blockers[b] != 0 && blockers[b] == srcs[s]) e_haz = 1'b1;

`ifdef HAZARD_FORWARDING_EN
        e_fa = reset ? 2'b00 : model_fwd(ex_rs);
        e_fb = reset ? 2'b00 : model_fwd(ex_rt);
`else
        e_fa = 2'b00;
        e_fb = 2'b00;
`endif

        {e_pc, e_ifw, e_bub, e_f1, e_f2, e_f3} = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if (reset) begin
            {e_pc, e_ifw, e_bub, e_f1, e_f2, e_f3} = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        end else if (mem_branch_taken) begin
            {e_f1, e_f2, e_f3} = 3'b111;
        end else if (m_rem > 0) begin
            e_f1 = 1'b1;
        end else if (e_haz) begin
            {e_pc, e_ifw, e_bub} = 3'b001;
        end

        check("pc_write", 16'(pc_write), 16'(e_pc));
        check("ifid_write", 16'(ifid_write), 16'(e_ifw));
        check("idex_bubble", 16'(idex_bubble), 16'(e_bub));
        check("ifid_flush", 16'(ifid_flush), 16'(e_f1));
        check("idex_flush", 16'(idex_flush), 16'(e_f2));
        check("exmem_flush", 16'(exmem_flush), 16'(e_f3));
        check("fwd_a", 16'(fwd_a), 16'(e_fa));
        check("fwd_b", 16'(fwd_b), 16'(e_fb));
        check("stall_cnt", 16'(stall_cnt), 16'(m_stall));
        check("flush_cnt", 16'(flush_cnt), 16'(m_flush));
        if (!reset) check("dbg_state", 16'(dbg_state), 16'(m_rem > 0));

        // Advance model to the state after the coming posedge.
        if (reset) begin
            m_rem = 0; m_stall = 0; m_flush = 0;
        end else if (mem_branch_taken) begin
            m_rem = FC - 1;
            if (m_flush < SAT) m_flush++;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (e_haz) begin
            if (m_stall < SAT) m_stall++;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {id_valid, id_uses_rt, ex_mem_read, ex_reg_write} = '0;
        {mem_reg_write, wb_reg_write, mem_branch_taken} = '0;
        {id_rs, id_rt, ex_dst, ex_rs, ex_rt, mem_dst, wb_dst} = '0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] dst);
        id_valid = 1'b1; id_rs = 8; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = dst;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_pc_write", 16'(pc_write), 16'h0);
        check("rst_bubble", 16'(idex_bubble), 16'h1);
        check("rst_flushes", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h7);
        tick();
        @(negedge clk);
        check("rst_stall_cnt", 16'(stall_cnt), 16'h0);
        check("rst_flush_cnt", 16'(flush_cnt), 16'h0);
        tick(); reset = 1'b0;
        @(negedge clk);
        check("post_rst_pc_write", 16'(pc_write), 16'h1);
        check("post_rst_flushes", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h0);

        // lw $8 in EX, add using $8 in ID: one bubble.
        tick(); set_load_use(5'd8);
        @(negedge clk);
        check("lu_pc_write", 16'(pc_write), 16'h0);
        check("lu_bubble", 16'(idex_bubble), 16'h1);
        tick(); clear_inputs();
        @(negedge clk);
        check("lu_stall_cnt", 16'(stall_cnt), 16'h1);
        check("lu_released", 16'(pc_write), 16'h1);

        // Load into x0 is not a hazard.
        tick(); set_load_use(5'd0); id_rs = 0;
        @(negedge clk);
        check("x0_pc_write", 16'(pc_write), 16'h1);
        tick(); clear_inputs();
        @(negedge clk);
        check("x0_stall_cnt", 16'(stall_cnt), 16'h1);

        // Taken branch, FC=3: full flush then two ifid-only cycles.
        tick(); mem_branch_taken = 1'b1;
        @(negedge clk);
        check("br_flushes", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h7);
        tick(); clear_inputs();
        @(negedge clk);
        check("br_tail1", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h4);
        tick();
        @(negedge clk);
        check("br_tail2", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h4);
        tick();
        @(negedge clk);
        check("br_done", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h0);
        check("br_flush_cnt", 16'(flush_cnt), 16'h1);

        // Branch beats load-use.
        tick(); set_load_use(5'd8); mem_branch_taken = 1'b1;
        @(negedge clk);
        check("brlu_flushes", 16'({ifid_flush, idex_flush, exmem_flush}), 16'h7);
        check("brlu_bubble", 16'(idex_bubble), 16'h0);
        tick(); clear_inputs();
        @(negedge clk);
        check("brlu_stall_cnt", 16'(stall_cnt), 16'h1);
        check("brlu_flush_cnt", 16'(flush_cnt), 16'h2);
        tick(); tick();

`ifdef HAZARD_FORWARDING_EN
        tick(); mem_reg_write = 1; mem_dst = 5; wb_reg_write = 1; wb_dst = 5; ex_rs = 5; ex_rt = 5;
        @(negedge clk);
        check("fwd_a_mem", 16'(fwd_a), 16'h2);
        check("fwd_b_mem", 16'(fwd_b), 16'h2);
        tick(); mem_reg_write = 0;
        @(negedge clk);
        check("fwd_a_wb", 16'(fwd_a), 16'h1);
        tick(); clear_inputs();
`else
        // add $9 followed by a consumer: stalls while the writer is in EX and MEM.
        tick(); id_valid = 1; id_rs = 9; ex_reg_write = 1; ex_dst = 9;
        @(negedge clk);
        check("raw_ex_pc", 16'(pc_write), 16'h0);
        tick(); ex_reg_write = 0; ex_dst = 0; mem_reg_write = 1; mem_dst = 9;
        @(negedge clk);
        check("raw_mem_pc", 16'(pc_write), 16'h0);
        tick(); mem_reg_write = 0; mem_dst = 0; wb_reg_write = 1; wb_dst = 9;
        @(negedge clk);
        check("raw_wb_pc", 16'(pc_write), 16'h1);
        tick(); clear_inputs();
        @(negedge clk);
        check("raw_stall_cnt", 16'(stall_cnt), 16'h3);
`endif

        // Saturation of the stall counter.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; set_load_use(5'd8);
        repeat (SAT + 5) tick();
        clear_inputs();
        @(negedge clk);
        check("stall_sat", 16'(stall_cnt), 16'(SAT));

        // Randomized traffic, including occasional mid-operation reset.
        repeat (3000) begin
            tick();
            reset            = ($urandom_range(0, 99) == 0);
            id_valid         = ($urandom_range(0, 9) < 8);
            id_uses_rt       = $urandom_range(0, 1);
            id_rs            = AW'($urandom_range(0, 3));
            id_rt            = AW'($urandom_range(0, 3));
            ex_mem_read      = ($urandom_range(0, 9) < 4);
            ex_reg_write     = $urandom_range(0, 1);
            ex_dst           = AW'($urandom_range(0, 3));
            ex_rs            = AW'($urandom_range(0, 3));
            ex_rt            = AW'($urandom_range(0, 3));
            mem_reg_write    = $urandom_range(0, 1);
            mem_dst          = AW'($urandom_range(0, 3));
            wb_reg_write     = $urandom_range(0, 1);
            wb_dst           = AW'($urandom_range(0, 3));
            mem_branch_taken = ($urandom_range(0, 99) < 8);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
